// File: rtl/word_red.sv
// Sequencer around an external word_red datapath: iterates the word reduction
// NITER times on one operand and optionally applies a final subtraction of q.
module word_red_seq #(
  parameter int K         = 120,
  parameter int R         = 34,
  parameter int LOGQH     = 26,
  parameter int O_SIZE    = K - R + 1,
  parameter int LAT       = 3,
  parameter int NITER     = 2,
  parameter int FINAL_SUB = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_C,
  input  logic [LOGQH-1:0]  in_qH,
  input  logic [O_SIZE-1:0] q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [O_SIZE-1:0] out_T,
  output logic              busy,
  output logic [K-1:0]      dp_C,
  output logic [LOGQH-1:0]  dp_qH,
  input  logic [O_SIZE-1:0] dp_T
);

  localparam int IT_W  = $clog2(NITER) + 1;
  localparam int CNT_W = $clog2(LAT + 1) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IT_W-1:0]  it_r;
  logic [CNT_W-1:0] cnt_r;
  logic             word_done_s;
  logic             last_iter_s;

  // dp_T is trusted only once the datapath pipeline has had LAT cycles to settle
  assign word_done_s = (cnt_r == CNT_W'(LAT));
  assign last_iter_s = (it_r == IT_W'(NITER - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (word_done_s && last_iter_s) begin
          state_s = (FINAL_SUB != 0) ? SUB : DONE;
        end else begin
          state_s = RUN;
        end
      end
      SUB: begin
        state_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operand, counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_C  <= '0;
      dp_qH <= '0;
      it_r  <= '0;
      cnt_r <= '0;
      out_T <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dp_C  <= in_C;
            dp_qH <= in_qH;
            it_r  <= '0;
            cnt_r <= '0;
          end
        end
        RUN: begin
          if (!word_done_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else if (!last_iter_s) begin
            // Feed the reduced word back as the next operand
            dp_C  <= K'(dp_T);
            it_r  <= it_r + IT_W'(1);
            cnt_r <= '0;
          end else begin
            out_T <= dp_T;
          end
        end
        SUB: begin
          if (out_T >= q) begin
            out_T <= out_T - q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake and status outputs, registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_s == IDLE);
      busy      <= (state_s != IDLE);
      out_valid <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_word_red_seq.sv
// Self-checking bench for word_red_seq with a behavioural word_red datapath
// (T = C_H + (C_L != 0) + C_L*qH, pipelined LAT cycles) and an iterated golden model.
module tb_word_red_seq;

  localparam int K      = 120;
  localparam int R      = 34;
  localparam int LOGQH  = 26;
  localparam int O_SIZE = K - R + 1;
  localparam int LAT    = 3;
  localparam int NITER  = 2;
  localparam int FSUB   = 1;
  localparam int LATENCY = NITER * (LAT + 1) + FSUB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [K-1:0]      in_C = '0;
  logic [LOGQH-1:0]  in_qH = '0;
  logic [O_SIZE-1:0] q = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [O_SIZE-1:0] out_T;
  logic              busy;
  logic [K-1:0]      dp_C;
  logic [LOGQH-1:0]  dp_qH;
  logic [O_SIZE-1:0] dp_T;

  int errors = 0;
  int checks = 0;

  word_red_seq #(.K(K), .R(R), .LOGQH(LOGQH), .O_SIZE(O_SIZE), .LAT(LAT),
                 .NITER(NITER), .FINAL_SUB(FSUB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_C(in_C), .in_qH(in_qH), .q(q), .out_valid(out_valid),
    .out_ready(out_ready), .out_T(out_T), .busy(busy),
    .dp_C(dp_C), .dp_qH(dp_qH), .dp_T(dp_T)
  );

  always #5 clk = ~clk;

  function automatic logic [O_SIZE-1:0] word_red_f(input logic [K-1:0] c,
                                                   input logic [LOGQH-1:0] qh);
    logic [K-1:0] hi;
    logic [R-1:0] lo;
    hi = c >> R;
    lo = c[R-1:0];
    return O_SIZE'(hi) + O_SIZE'(lo != '0) + O_SIZE'(lo) * O_SIZE'(qh);
  endfunction

  function automatic logic [O_SIZE-1:0] golden(input logic [K-1:0] c,
                                               input logic [LOGQH-1:0] qh,
                                               input logic [O_SIZE-1:0] qq);
    logic [K-1:0] cur;
    logic [O_SIZE-1:0] t;
    cur = c;
    t = '0;
    for (int i = 0; i < NITER; i++) begin
      t = word_red_f(cur, qh);
      cur = K'(t);
    end
    if (FSUB != 0 && t >= qq) t = t - qq;
    return t;
  endfunction

  // Datapath model: LAT pipeline stages after the combinational reduction
  logic [O_SIZE-1:0] pipe [0:LAT-1];
  always @(posedge clk) begin
    pipe[0] <= word_red_f(dp_C, dp_qH);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_T = pipe[LAT-1];

  function automatic logic [K-1:0] rand_c();
    return K'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [O_SIZE-1:0] rand_q();
    logic [O_SIZE-1:0] v;
    v = O_SIZE'({$urandom(), $urandom(), $urandom()});
    return v >> $urandom_range(0, O_SIZE - 1);
  endfunction

  // Present one operand at a negedge; returns at the negedge after the accept edge
  task automatic start_op(input logic [K-1:0] c, input logic [LOGQH-1:0] qh);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_C = c;
    in_qH = qh;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/valid=%b required 100", {in_ready, busy, out_valid});
    end
    checks++;
    if (out_T !== '0 || dp_C !== '0 || dp_qH !== '0) begin
      errors++;
      $display("FAIL reset_regs: out_T=%0h dp_C=%0h dp_qH=%0h required 0", out_T, dp_C, dp_qH);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [O_SIZE-1:0] qq, input logic [O_SIZE-1:0] exp_t);
    logic [K-1:0] c;
    int n;
    c = {{(K-3){1'b0}}, 3'd5} << R;
    q = qq;
    out_ready = 1'b1;
    start_op(c, '0);
    wait_valid(n);
    checks++;
    if (n !== LATENCY) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required %0d", n, LATENCY);
    end
    checks++;
    if (out_T !== exp_t) begin
      errors++;
      $display("FAIL basic_result q=%0d: got %0h required %0h", qq, out_T, exp_t);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: valid=%0b ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero();
    int n;
    q = rand_q() | O_SIZE'(1);
    out_ready = 1'b1;
    start_op('0, LOGQH'($urandom()));
    n = 0;
    while (n < LATENCY) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_busy cycle %0d: ready/busy/valid=%b required 010", n, {in_ready, busy, out_valid});
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_T !== '0) begin
      errors++;
      $display("FAIL zero_result: valid=%0b out_T=%0h required 1 0", out_valid, out_T);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [K-1:0] c;
    logic [LOGQH-1:0] qh;
    logic [O_SIZE-1:0] exp_t;
    int n;
    c = rand_c();
    qh = LOGQH'($urandom());
    q = rand_q();
    exp_t = golden(c, qh, q);
    out_ready = 1'b0;
    start_op(c, qh);
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_T !== exp_t || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold %0d: valid=%0b ready=%0b out_T=%0h required 1 0 %0h", i, out_valid, in_ready, out_T, exp_t);
      end
      in_valid = ~in_valid;
      in_C = rand_c();
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: valid=%0b ready=%0b busy=%0b required 0 1 0", out_valid, in_ready, busy);
    end
    c = rand_c();
    qh = LOGQH'($urandom());
    exp_t = golden(c, qh, q);
    start_op(c, qh);
    wait_valid(n);
    checks++;
    if (n !== LATENCY || out_T !== exp_t) begin
      errors++;
      $display("FAIL bp_next: latency %0d out_T=%0h required %0d %0h", n, out_T, LATENCY, exp_t);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [K-1:0] c;
    logic [LOGQH-1:0] qh;
    logic [O_SIZE-1:0] exp_t;
    int n;
    out_ready = 1'b1;
    start_op(rand_c(), LOGQH'($urandom()));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || dp_C !== '0) begin
      errors++;
      $display("FAIL midrst_state: ready=%0b busy=%0b valid=%0b dp_C=%0h required 1 0 0 0", in_ready, busy, out_valid, dp_C);
    end
    c = rand_c();
    qh = LOGQH'($urandom());
    q = rand_q();
    exp_t = golden(c, qh, q);
    start_op(c, qh);
    wait_valid(n);
    checks++;
    if (n !== LATENCY || out_T !== exp_t) begin
      errors++;
      $display("FAIL midrst_next: latency %0d out_T=%0h required %0d %0h", n, out_T, LATENCY, exp_t);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [O_SIZE-1:0] expq[$];
    logic [O_SIZE-1:0] exp_t;
    int sent, recv, cyc;
    sent = 0;
    recv = 0;
    cyc = 0;
    while ((sent < 200 || recv < 200) && cyc < 200 * 40) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_ready && sent < 200) begin
        in_C = rand_c();
        in_qH = LOGQH'($urandom());
        q = rand_q();
        in_valid = 1'b1;
        expq.push_back(golden(in_C, in_qH, q));
        sent++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end else begin
        in_valid = $urandom_range(0, 1) != 0;
        in_C = rand_c();
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: result %0h with no operand pending", out_T);
        end else begin
          exp_t = expq.pop_front();
          if (out_T !== exp_t) begin
            errors++;
            $display("FAIL rand_result %0d: got %0h required %0h", recv, out_T, exp_t);
          end
        end
        recv++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== 200 || expq.size() != 0) begin
      errors++;
      $display("FAIL rand_count: received %0d pending %0d required 200 0", recv, expq.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic(O_SIZE'(7), O_SIZE'(1));
    test_basic(O_SIZE'(1), O_SIZE'(0));
    test_zero();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
